load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the MEM stage of the MIPS pipeline and the word-addressed data memory. It accepts one load or store request at a time and issues word-aligned read and write strobes to the memory. Byte and halfword stores are done as read-modify-write. Load results are extracted and extended before they return to the pipeline, and misaligned or out-of-range accesses are flagged without touching memory.

## Interface
- MEM_WORDS, 8192, data memory depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid; accepted only while FSM is IDLE
- store  in  1  1 = store, 0 = load
- op  in  3  opcode[2:0]; loads: 000 lb, 001 lh, 011 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 011 sw
- addr  in  32  byte address
- wdata  in  32  store data; the low byte or low halfword is used for sb/sh
- busy  out  1  FSM not IDLE; the pipeline stalls on it
- done  out  1  one-cycle completion pulse
- fault  out  1  with done: request rejected, no memory access made
- rdata  out  32  load result; held until the next load completes
- mem_address  out  32  word-aligned byte address to memory (addr & ~3)
- mem_writeData  out  32  full word to write
- mem_read, mem_write  out  1  access strobes; never both high
- mem_readData  in  32  combinational read data from memory

## Operation
- Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24, and addr[1:0]=3 selects bits 7:0. For halfwords, addr[1]=0 selects bits 31:16.
- FSM states are IDLE, RD and WR. Accept happens in IDLE when req=1, and op, store, addr and wdata are registered at accept.
- A request faults if any of these hold:
  - the op encoding is illegal (010, 110, 111 for loads; 010 or 1xx for stores);
  - it is a halfword access with addr[0]=1;
  - it is a word access with addr[1:0]≠0;
  - addr ≥ 4*MEM_WORDS.
- On a fault the FSM stays in IDLE, and done=1 and fault=1 in the next cycle. Memory strobes stay low and rdata is unchanged.
- State transitions:
  - Load: IDLE→RD→IDLE. In RD, mem_read=1, and mem_readData is captured on the edge that ends RD. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
  - sw: IDLE→WR→IDLE with mem_write=1 and mem_writeData=wdata.
  - sb/sh: IDLE→RD→WR→IDLE. The word read in RD has the selected lane replaced by wdata[7:0] or wdata[15:0], other lanes are preserved, and the merged word is written in WR.
- done is registered: it rises in the IDLE cycle after the final access, with fault=0 for a successful access.
- In the done cycle the FSM is IDLE. A req present in that cycle is accepted as a new request, so back-to-back operation is legal. Upstream must drop req in the done cycle unless it is issuing a new operation.
- req while busy=1 is ignored, and no queueing is done.
- Stores leave rdata unchanged.

## Timing
- Reset values: busy=0, done=0, fault=0, rdata=0, mem_address=0, mem_writeData=0, mem_read=0, mem_write=0, FSM in IDLE.
- Reset asserted mid-operation returns everything to reset values immediately.
  - Any in-flight RMW is abandoned, and a WR strobe is dropped the same instant.
  - No done pulse is produced for the aborted request.
- With accept on edge T, done is high:
  - in cycle T+1 for a fault;
  - in cycle T+2 for lw, lb, lbu, lh, lhu and sw;
  - in cycle T+3 for sb and sh.
- Each strobe is high for exactly one cycle per access. mem_address and mem_writeData are stable for that whole cycle and return to 0 in IDLE.
- busy=1 exactly in RD and WR cycles.
- rdata updates on the same edge that raises done for a load.

## Test plan
- Load extension: preload word 4 (addr 0x10) = 0x80FF7F01, then:
  - lb at 0x10 → rdata=0xFFFFFF80;
  - lbu at 0x10 → 0x00000080;
  - lh at 0x12 → 0x00007F01;
  - lhu at 0x10 → 0x000080FF;
  - lw at 0x10 → 0x80FF7F01.
  - Each completes with done at T+2 and busy high for 1 cycle.
- Read-modify-write: word 4 = 0x11223344.
  - sb wdata=0xAB at 0x11 → word 0x11AB3344.
  - Then sh wdata=0xCDEF at 0x12 → word 0x11ABCDEF.
  - Each shows mem_read for 1 cycle, then mem_write for 1 cycle, then done at T+3.
- Faults each give done=1 and fault=1 at T+1 with no strobes and rdata unchanged:
  - lw at 0x02;
  - sh at 0x13;
  - load op=010;
  - lw at 0x8000 (MEM_WORDS=8192).
- Back-to-back: sw 0xDEADBEEF at 0x20, with a new req lw at 0x20 presented in the done cycle. The lw is accepted there and returns 0xDEADBEEF two cycles later. A req presented during busy is ignored.
- Reset mid-RMW: drop rst_n during the RD cycle of sb at 0x11. All outputs go to 0 immediately, no mem_write occurs, word 4 is unchanged, and there is no done pulse. After release, a new lw completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store sequencer for a word-addressed data memory
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        store,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readData
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_t      state;
  logic        store_q;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        bad_op;
  logic        misaligned;
  logic        out_of_range;
  logic        reject;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  // op[1:0] doubles as the access size: 00 byte, 01 halfword, 11 word.
  always_comb begin
    bad_op = 1'b0;
    if (store) bad_op = op[2] | (op[1:0] == 2'b10);
    else       bad_op = (op[1:0] == 2'b10) | (op[2] & op[1]);
    misaligned   = ((op[1:0] == 2'b01) && addr[0]) ||
                   ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
    reject       = bad_op | misaligned | out_of_range;
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    sel_byte = mem_readData[31:24];
    case (lane_q)
      2'd0: sel_byte = mem_readData[31:24];
      2'd1: sel_byte = mem_readData[23:16];
      2'd2: sel_byte = mem_readData[15:8];
      2'd3: sel_byte = mem_readData[7:0];
      default: sel_byte = mem_readData[31:24];
    endcase
    sel_half = lane_q[1] ? mem_readData[15:0] : mem_readData[31:16];
    case (op_q[1:0])
      2'b00:   load_val = op_q[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = op_q[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_val = mem_readData;
    endcase
  end

  always_comb begin
    merged = mem_readData;
    if (op_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = mem_readData;
      endcase
    end else if (lane_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      store_q       <= 1'b0;
      op_q          <= 3'd0;
      lane_q        <= 2'd0;
      wdata_q       <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      rdata         <= 32'd0;
      mem_address   <= 32'd0;
      mem_writeData <= 32'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (reject) begin
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              store_q     <= store;
              op_q        <= op;
              lane_q      <= addr[1:0];
              wdata_q     <= wdata;
              mem_address <= {addr[31:2], 2'b00};
              busy        <= 1'b1;
              if (store && (op[1:0] == 2'b11)) begin
                state         <= WR;
                mem_write     <= 1'b1;
                mem_writeData <= wdata;
              end else begin
                state    <= RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (store_q) begin
            state         <= WR;
            mem_write     <= 1'b1;
            mem_writeData <= merged;
          end else begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            rdata       <= load_val;
            mem_address <= 32'd0;
          end
        end
        WR: begin
          state         <= IDLE;
          mem_write     <= 1'b0;
          mem_writeData <= 32'd0;
          mem_address   <= 32'd0;
          busy          <= 1'b0;
          done          <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
// Reference model keeps memory as a big-endian byte array.
module tb_load_store_unit;
  localparam int MEM_WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, fault, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_writeData, mem_readData;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic        mem_inited = 1'b0;
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_val = 32'd0;
  logic [7:0]  ref_bytes [0:4*MEM_WORDS-1];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_rdata = 32'd0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .store(store), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_read(mem_read),
    .mem_write(mem_write), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  assign mem_readData = mem[mem_address[14:2]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[14:2]] <= mem_writeData;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end
  end

  function automatic int ref_size(input logic [2:0] o);
    case (o[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_fault(input logic st, input logic [2:0] o, input logic [31:0] a);
    int     code;
    longint ua;
    code = int'(o);
    ua   = longint'(a);
    if (st ? !(code inside {0, 1, 3}) : !(code inside {0, 1, 3, 4, 5})) return 1'b1;
    if (ua % longint'(ref_size(o)) != 0) return 1'b1;
    if (ua >= longint'(4 * MEM_WORDS)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
    longint v;
    int     n;
    n = ref_size(o);
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | longint'(ref_bytes[int'(a) + i]);
    if (!o[2] && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx], ref_bytes[4*idx+1], ref_bytes[4*idx+2], ref_bytes[4*idx+3]};
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
    int n;
    n = ref_size(o);
    for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = 8'(w >> (8 * (n - 1 - i)));
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[4*idx+i] = 8'(v >> (24 - 8 * i));
  endtask

  // Issues one request and watches the bus until done (bounded), counting strobes and busy cycles.
  task automatic run_op(input logic st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        output int lat, output int nrd, output int nwr, output int nb,
                        output logic flt, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; store = st; op = o; addr = a; wdata = w;
    @(negedge clk);
    req = 1'b0;
    lat = 1; nrd = 0; nwr = 0; nb = 0;
    while (done !== 1'b1 && lat < 8) begin
      nrd += int'(mem_read); nwr += int'(mem_write); nb += int'(busy);
      if (mem_read && mem_write) nrd += 100;
      @(negedge clk);
      lat++;
    end
    nrd += int'(mem_read); nwr += int'(mem_write); nb += int'(busy);
    flt = fault;
    rd  = rdata;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, fault, mem_read, mem_write} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {busy, done, fault, mem_read, mem_write}); end
    n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if ({mem_address, mem_writeData} !== 64'd0) begin n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", mem_address, mem_writeData); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_ext;
    logic [2:0]  ops  [5];
    logic [31:0] adrs [5];
    logic [31:0] want [5];
    int lat, nrd, nwr, nb;
    logic flt;
    logic [31:0] rd;
    ops  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd3};
    adrs = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h10};
    want = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'h80FF7F01};
    poke(4, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ops[i], adrs[i], $urandom, lat, nrd, nwr, nb, flt, rd);
      exp_rdata = want[i];
      n_cmp++; if (rd !== want[i]) begin n_fail++; $display("FAIL load_ext_rdata[%0d] got %h want %h", i, rd, want[i]); end
      n_cmp++; if (lat != 2 || nb != 1 || flt !== 1'b0) begin n_fail++; $display("FAIL load_ext_timing[%0d] got lat=%0d busy=%0d fault=%b want 2/1/0", i, lat, nb, flt); end
      n_cmp++; if (nrd != 1 || nwr != 0) begin n_fail++; $display("FAIL load_ext_strobes[%0d] got rd=%0d wr=%0d want 1/0", i, nrd, nwr); end
    end
  endtask

  task automatic test_rmw;
    logic [2:0]  ops  [2];
    logic [31:0] adrs [2];
    logic [31:0] wds  [2];
    logic [31:0] want [2];
    int lat, nrd, nwr, nb;
    logic flt;
    logic [31:0] rd;
    ops  = '{3'd0, 3'd1};
    adrs = '{32'h11, 32'h12};
    wds  = '{32'hFFFF00AB, 32'h1234CDEF};
    want = '{32'h11AB3344, 32'h11ABCDEF};
    poke(4, 32'h11223344);
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, ops[i], adrs[i], wds[i], lat, nrd, nwr, nb, flt, rd);
      ref_store(ops[i], adrs[i], wds[i]);
      n_cmp++; if (mem[4] !== want[i]) begin n_fail++; $display("FAIL rmw_word[%0d] got %h want %h", i, mem[4], want[i]); end
      n_cmp++; if (lat != 3 || nb != 2 || nrd != 1 || nwr != 1 || flt !== 1'b0) begin n_fail++; $display("FAIL rmw_timing[%0d] got lat=%0d busy=%0d rd=%0d wr=%0d fault=%b want 3/2/1/1/0", i, lat, nb, nrd, nwr, flt); end
      n_cmp++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL rmw_rdata_held[%0d] got %h want %h", i, rd, exp_rdata); end
    end
  endtask

  task automatic test_faults;
    logic        sts  [4];
    logic [2:0]  ops  [4];
    logic [31:0] adrs [4];
    int lat, nrd, nwr, nb;
    logic flt;
    logic [31:0] rd;
    sts  = '{1'b0, 1'b1, 1'b0, 1'b0};
    ops  = '{3'd3, 3'd1, 3'd2, 3'd3};
    adrs = '{32'h02, 32'h13, 32'h10, 32'h8000};
    for (int i = 0; i < 4; i++) begin
      run_op(sts[i], ops[i], adrs[i], $urandom, lat, nrd, nwr, nb, flt, rd);
      n_cmp++; if (flt !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL fault_flag[%0d] got fault=%b lat=%0d want 1/1", i, flt, lat); end
      n_cmp++; if (nrd != 0 || nwr != 0 || nb != 0) begin n_fail++; $display("FAIL fault_quiet[%0d] got rd=%0d wr=%0d busy=%0d want 0/0/0", i, nrd, nwr, nb); end
      n_cmp++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL fault_rdata[%0d] got %h want %h", i, rd, exp_rdata); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req = 1'b1; store = 1'b1; op = 3'd3; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (!(busy && mem_write && !mem_read && mem_address == 32'h20 && mem_writeData == 32'hDEADBEEF)) begin n_fail++; $display("FAIL b2b_sw_wr got busy=%b wr=%b rd=%b addr=%h data=%h want 1/1/0/20/deadbeef", busy, mem_write, mem_read, mem_address, mem_writeData); end
    store = 1'b0; addr = 32'h24;
    @(negedge clk);
    n_cmp++; if (!(done && !fault && !busy)) begin n_fail++; $display("FAIL b2b_sw_done got done=%b fault=%b busy=%b want 1/0/0", done, fault, busy); end
    addr = 32'h20;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (!(mem_read && busy && !done && mem_address == 32'h20)) begin n_fail++; $display("FAIL b2b_lw_rd got rd=%b busy=%b done=%b addr=%h want 1/1/0/20", mem_read, busy, done, mem_address); end
    @(negedge clk);
    ref_store(3'd3, 32'h20, 32'hDEADBEEF);
    exp_rdata = 32'hDEADBEEF;
    n_cmp++; if (!(done && !fault) || rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_lw_done got done=%b fault=%b rdata=%h want 1/0/deadbeef", done, fault, rdata); end
    @(negedge clk);
    n_cmp++; if (done || busy || mem_read || mem_write) begin n_fail++; $display("FAIL b2b_ignored_req got done=%b busy=%b rd=%b wr=%b want all 0", done, busy, mem_read, mem_write); end
    n_cmp++; if (mem[8] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_mem got %h want deadbeef", mem[8]); end
  endtask

  task automatic test_reset_mid_rmw;
    int wr_seen, done_seen, lat, nrd, nwr, nb;
    logic flt;
    logic [31:0] rd;
    poke(4, 32'h11223344);
    @(negedge clk);
    req = 1'b1; store = 1'b1; op = 3'd0; addr = 32'h11; wdata = 32'hAB;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL abort_in_rd got rd=%b want 1", mem_read); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, fault, mem_read, mem_write} !== 5'b0 || rdata !== 32'd0 || mem_address !== 32'd0 || mem_writeData !== 32'd0) begin n_fail++; $display("FAIL abort_outputs got flags=%b rdata=%h addr=%h wd=%h want all 0", {busy, done, fault, mem_read, mem_write}, rdata, mem_address, mem_writeData); end
    exp_rdata = 32'd0;
    wr_seen = 0; done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      wr_seen += int'(mem_write); done_seen += int'(done);
    end
    n_cmp++; if (wr_seen != 0 || done_seen != 0) begin n_fail++; $display("FAIL abort_quiet got wr=%0d done=%0d want 0/0", wr_seen, done_seen); end
    n_cmp++; if (mem[4] !== 32'h11223344) begin n_fail++; $display("FAIL abort_mem got %h want 11223344", mem[4]); end
    run_op(1'b0, 3'd3, 32'h10, 32'd0, lat, nrd, nwr, nb, flt, rd);
    exp_rdata = 32'h11223344;
    n_cmp++; if (rd !== 32'h11223344 || lat != 2 || flt !== 1'b0) begin n_fail++; $display("FAIL abort_recover got rdata=%h lat=%0d fault=%b want 11223344/2/0", rd, lat, flt); end
  endtask

  task automatic test_random;
    logic        st, ef, flt;
    logic [2:0]  o;
    logic [31:0] a, w, rd;
    int sel, sz, exp_lat, exp_rd, exp_wr, lat, nrd, nwr, nb, idx;
    for (int it = 0; it < 300; it++) begin
      st  = 1'($urandom_range(0, 1));
      o   = 3'($urandom_range(0, 7));
      w   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 63));
      else if (sel == 7) a = 32'($urandom_range(4 * MEM_WORDS - 6, 4 * MEM_WORDS + 3));
      else               a = $urandom;
      ef      = ref_fault(st, o, a);
      sz      = ref_size(o);
      exp_lat = ef ? 1 : ((st && sz < 4) ? 3 : 2);
      exp_rd  = (!ef && (!st || sz < 4)) ? 1 : 0;
      exp_wr  = (!ef && st) ? 1 : 0;
      run_op(st, o, a, w, lat, nrd, nwr, nb, flt, rd);
      if (!ef && !st) exp_rdata = ref_load(o, a);
      if (!ef && st) ref_store(o, a, w);
      idx = int'(a[14:2]);
      n_cmp++; if (flt !== ef || lat != exp_lat) begin n_fail++; $display("FAIL rnd_status[%0d] st=%b op=%0d a=%h got fault=%b lat=%0d want %b/%0d", it, st, o, a, flt, lat, ef, exp_lat); end
      n_cmp++; if (nrd != exp_rd || nwr != exp_wr || nb != exp_lat - 1) begin n_fail++; $display("FAIL rnd_strobes[%0d] st=%b op=%0d a=%h got rd=%0d wr=%0d busy=%0d want %0d/%0d/%0d", it, st, o, a, nrd, nwr, nb, exp_rd, exp_wr, exp_lat - 1); end
      n_cmp++; if (rd !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] st=%b op=%0d a=%h got %h want %h", it, st, o, a, rd, exp_rdata); end
      n_cmp++; if (mem[idx] !== ref_word(idx)) begin n_fail++; $display("FAIL rnd_mem[%0d] word %0d got %h want %h", it, idx, mem[idx], ref_word(idx)); end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = 8'(init_word(i) >> (24 - 8 * b));
    end
    test_reset;
    test_load_ext;
    test_rmw;
    test_faults;
    test_back_to_back;
    test_reset_mid_rmw;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
